// File: rtl/pc_gen_if_if.sv
// Fetch-address generator bus: redirect/stall requests in, fetch PC and status out.
// The misalign_o signal exists only when PC_ALIGN_CHK_EN is defined.
interface pc_gen_if_if #(
   parameter int XLEN = 32
);
   logic            stall_i;
   logic            br_taken_i;
   logic [XLEN-1:0] br_base_i;
   logic [XLEN-1:0] br_offset_i;
   logic            jmp_i;
   logic [XLEN-1:0] jmp_target_i;
   logic [XLEN-1:0] pc_o;
   logic [XLEN-1:0] pc_plus_o;
   logic            flush_o;
   logic            valid_o;
`ifdef PC_ALIGN_CHK_EN
   logic            misalign_o;
`endif

   modport master (
`ifdef PC_ALIGN_CHK_EN
      input  misalign_o,
`endif
      output stall_i, br_taken_i, br_base_i, br_offset_i, jmp_i, jmp_target_i,
      input  pc_o, pc_plus_o, flush_o, valid_o
   );

   modport slave (
`ifdef PC_ALIGN_CHK_EN
      output misalign_o,
`endif
      input  stall_i, br_taken_i, br_base_i, br_offset_i, jmp_i, jmp_target_i,
      output pc_o, pc_plus_o, flush_o, valid_o
   );
endinterface

// File: rtl/pc_gen_if.sv
// IF-stage fetch-address generator: PC register, sequential increment, jump/branch
// redirect (beats stall), stall hold and IF/ID flush pulse. Optional macro PC_ALIGN_CHK_EN.
module pc_gen_if #(
   parameter int          XLEN      = 32,
   parameter logic [31:0] RESET_PC  = 32'h0000_0000,
   parameter int          INC       = 4,
   parameter int          OFF_SHIFT = 2
) (
   input logic         clk,
   input logic         rst_n,
   pc_gen_if_if.slave  bus
);

   localparam logic [XLEN-1:0] RESET_PC_X = XLEN'(RESET_PC);
   localparam logic [XLEN-1:0] INC_X      = XLEN'(INC);

   typedef enum logic [0:0] {
      ST_BOOT = 1'b0,
      ST_RUN  = 1'b1
   } state_t;

   state_t          state_r;
   state_t          state_nxt_s;
   logic [XLEN-1:0] pc_r;
   logic [XLEN-1:0] pc_nxt_s;
   logic [XLEN-1:0] target_s;
   logic [XLEN-1:0] br_off_sh_s;
   logic            redir_s;
   logic            flush_r;
   logic            valid_r;
   logic            valid_nxt_s;

   // Left shift of the two's-complement offset; truncation makes it identical to <<<.
   assign br_off_sh_s = bus.br_offset_i << OFF_SHIFT;

   // State register: BOOT gives the reset PC one fetch slot before RUN.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_r <= ST_BOOT;
      end else begin
         state_r <= state_nxt_s;
      end
   end

   // Next-state logic.
   always_comb begin
      state_nxt_s = state_r;
      case (state_r)
         ST_BOOT: state_nxt_s = ST_RUN;
         ST_RUN:  state_nxt_s = ST_RUN;
         default: state_nxt_s = ST_BOOT;
      endcase
   end

   // Output/datapath logic: next PC in priority jump > branch > stall > increment.
   always_comb begin
      pc_nxt_s    = pc_r;
      target_s    = pc_r;
      redir_s     = 1'b0;
      valid_nxt_s = 1'b0;
      case (state_r)
         ST_BOOT: begin
            pc_nxt_s    = pc_r;
            valid_nxt_s = 1'b1;
         end
         ST_RUN: begin
            valid_nxt_s = 1'b1;
            if (bus.jmp_i) begin
               redir_s  = 1'b1;
               target_s = bus.jmp_target_i;
               pc_nxt_s = bus.jmp_target_i;
            end else if (bus.br_taken_i) begin
               redir_s  = 1'b1;
               target_s = bus.br_base_i + br_off_sh_s;
               pc_nxt_s = bus.br_base_i + br_off_sh_s;
            end else if (bus.stall_i) begin
               pc_nxt_s = pc_r;
            end else begin
               pc_nxt_s = pc_r + INC_X;
            end
         end
         default: begin
            pc_nxt_s    = RESET_PC_X;
            valid_nxt_s = 1'b0;
         end
      endcase
   end

   // PC, flush and valid registers.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         pc_r    <= RESET_PC_X;
         flush_r <= 1'b0;
         valid_r <= 1'b0;
      end else begin
         pc_r    <= pc_nxt_s;
         flush_r <= redir_s;
         valid_r <= valid_nxt_s;
      end
   end

   assign bus.pc_o      = pc_r;
   assign bus.pc_plus_o = pc_r + INC_X;
   assign bus.flush_o   = flush_r;
   assign bus.valid_o   = valid_r;

`ifdef PC_ALIGN_CHK_EN
   logic misalign_r;

   // True when any of the low OFF_SHIFT address bits is set.
   function automatic logic addr_misaligned(input logic [XLEN-1:0] addr);
      logic [XLEN-1:0] mask;
      mask = ({{(XLEN-1){1'b0}}, 1'b1} << OFF_SHIFT) - {{(XLEN-1){1'b0}}, 1'b1};
      return |(addr & mask);
   endfunction

   // One-cycle misalignment flag; the raw target is still loaded into the PC.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         misalign_r <= 1'b0;
      end else begin
         misalign_r <= redir_s & addr_misaligned(target_s);
      end
   end

   assign bus.misalign_o = misalign_r;
`endif

endmodule

// File: tb/tb_pc_gen_if.sv
// Self-checking bench for pc_gen_if: directed scenarios followed by random stimulus,
// all compared against a behavioural model of the fetch-address rules.
module tb_pc_gen_if;

   localparam logic [31:0] RST_PC = 32'h0000_3000;

   logic clk = 1'b0;
   logic rst_n;

   always #5 clk = ~clk;

   pc_gen_if_if #(.XLEN(32)) bus ();

   pc_gen_if #(
      .XLEN      (32),
      .RESET_PC  (RST_PC),
      .INC       (4),
      .OFF_SHIFT (2)
   ) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   int n_checks = 0;
   int n_errors = 0;

   logic [31:0] m_pc;
   logic        m_flush;
   logic        m_valid;
   logic        m_mis;

   task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   task automatic check_all(input string ph);
      check_val({ph, ".pc"}, bus.pc_o, m_pc);
      check_val({ph, ".pc_plus"}, bus.pc_plus_o, m_pc + 32'd4);
      check_val({ph, ".flush"}, {31'd0, bus.flush_o}, {31'd0, m_flush});
      check_val({ph, ".valid"}, {31'd0, bus.valid_o}, {31'd0, m_valid});
`ifdef PC_ALIGN_CHK_EN
      check_val({ph, ".misalign"}, {31'd0, bus.misalign_o}, {31'd0, m_mis});
`endif
   endtask

   task automatic model_reset();
      m_pc    = RST_PC;
      m_flush = 1'b0;
      m_valid = 1'b0;
      m_mis   = 1'b0;
   endtask

   task automatic drive(input logic st, input logic bt, input logic [31:0] bb,
                        input logic [31:0] bo, input logic j, input logic [31:0] jt);
      bus.stall_i      = st;
      bus.br_taken_i   = bt;
      bus.br_base_i    = bb;
      bus.br_offset_i  = bo;
      bus.jmp_i        = j;
      bus.jmp_target_i = jt;
   endtask

   // One clock: drive inputs, advance the model at the edge, compare on the falling edge.
   task automatic cycle(input string ph, input logic st, input logic bt, input logic [31:0] bb,
                        input logic [31:0] bo, input logic j, input logic [31:0] jt);
      logic [31:0] tgt;
      drive(st, bt, bb, bo, j, jt);
      @(posedge clk);
      if (!m_valid) begin
         m_valid = 1'b1;
         m_flush = 1'b0;
         m_mis   = 1'b0;
      end else if (j || bt) begin
         tgt     = j ? jt : bb + bo * 32'd4;
         m_pc    = tgt;
         m_flush = 1'b1;
         m_mis   = (tgt % 32'd4) != 32'd0;
      end else begin
         m_flush = 1'b0;
         m_mis   = 1'b0;
         if (!st) m_pc = m_pc + 32'd4;
      end
      @(negedge clk);
      check_all(ph);
   endtask

   initial begin
      rst_n = 1'b0;
      drive(1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
      model_reset();
      repeat (3) begin
         @(negedge clk);
         check_all("reset");
      end
      rst_n = 1'b1;
      cycle("boot", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
      cycle("seq1", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
      cycle("seq2", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

      cycle("jmp3c", 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h0000_003C);
      cycle("run40", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
      cycle("stall1", 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
      cycle("stall2", 1'b1, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
      cycle("after_stall", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

      cycle("br_neg", 1'b0, 1'b1, 32'h0000_0100, 32'hFFFF_FFFC, 1'b0, 32'd0);
      cycle("br_next", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

      cycle("prio", 1'b1, 1'b1, 32'h0000_0200, 32'h0000_0010, 1'b1, 32'h0000_0800);
      cycle("b2b", 1'b1, 1'b1, 32'h0000_1000, 32'h0000_0004, 1'b0, 32'd0);

      cycle("wrap_j", 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'hFFFF_FFF8);
      cycle("wrap_a", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
      cycle("wrap_b", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
      cycle("wrap_c", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

      // Reset arrives between edges while a branch is pending; inputs go X during reset.
      drive(1'b0, 1'b1, 32'h0000_0500, 32'h0000_0008, 1'b0, 32'd0);
      #2 rst_n = 1'b0;
      #1 model_reset();
      check_all("async_rst");
      drive(1'bx, 1'bx, 32'hxxxx_xxxx, 32'hxxxx_xxxx, 1'bx, 32'hxxxx_xxxx);
      @(negedge clk);
      check_all("rst_hold");
      rst_n = 1'b1;
      cycle("post_rst", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);
      cycle("post_rst2", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

      cycle("mis_j", 1'b0, 1'b0, 32'd0, 32'd0, 1'b1, 32'h0000_0802);
      cycle("mis_clr", 1'b0, 1'b0, 32'd0, 32'd0, 1'b0, 32'd0);

      for (int i = 0; i < 400; i++) begin
         logic [3:0]  r;
         logic [31:0] off;
         r   = 4'($urandom_range(0, 15));
         off = (r[0]) ? $urandom : 32'($signed($urandom_range(0, 64)) - 32);
         cycle("rand", ($urandom_range(0, 3) == 0), (r == 4'd1 || r == 4'd2),
               $urandom, off, (r == 4'd0), $urandom);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

// File: doc/pc_gen_if.md
Name: pc_gen_if

Overview:
- Parametrised fetch-address generator for the IF stage of the pipelined CPU.
- Successor to the fixed 32-bit offset adder: adds the PC register, sequential increment, branch and jump redirect, stall hold, and a flush pulse to the IF/ID register.
- Sits between the instruction-memory address port and the EX-stage branch resolution logic.

Parameters:
- XLEN, 32: address width in bits.
- RESET_PC, 32'h0000_0000: PC value loaded at reset; truncated or zero-extended to XLEN.
- INC, 4: sequential increment in bytes.
- OFF_SHIFT, 2: left shift applied to br_offset_i before it is added.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst_n  in  1  asynchronous, active-low reset.
- stall_i  in  1  hold the PC (load-use hazard or instruction-memory busy).
- br_taken_i  in  1  EX-stage conditional branch resolved taken.
- br_base_i  in  XLEN  PC of the branch instruction.
- br_offset_i  in  XLEN  signed offset, in units of 2^OFF_SHIFT bytes.
- jmp_i  in  1  unconditional jump request.
- jmp_target_i  in  XLEN  absolute jump target.
- pc_o  out  XLEN  current fetch address.
- pc_plus_o  out  XLEN  pc_o + INC, combinational; used for link addresses.
- flush_o  out  1  registered one-cycle pulse: invalidate IF/ID.
- valid_o  out  1  pc_o holds a live fetch address.

Behaviour:
- Reset (asynchronous on rst_n low):
  - pc_o = RESET_PC, flush_o = 0, valid_o = 0.
  - Reset mid-operation discards any pending redirect.
- First rising edge after rst_n deasserts: valid_o becomes 1 and pc_o stays at RESET_PC (a first fetch slot, not an increment). Internal state: BOOT, then RUN.
- In RUN, the next PC is chosen at each rising edge in this priority order:
  1. jmp_i = 1: pc <= jmp_target_i.
  2. br_taken_i = 1: pc <= br_base_i + (br_offset_i <<< OFF_SHIFT).
  3. stall_i = 1: pc <= pc (hold).
  4. otherwise: pc <= pc + INC.
- Redirect beats stall. If jmp_i or br_taken_i is high in the same cycle as stall_i, the redirect is taken. The stalled fetch is on the wrong path anyway.
- flush_o <= 1 for exactly one cycle after any redirect edge, otherwise 0. Back-to-back redirects give back-to-back flush pulses.
- Arithmetic is modulo 2^XLEN: no carry out, no overflow flag, and wrap-around is silent (e.g. all-ones + INC wraps to INC-1).
- br_offset_i is two's complement. The shift is arithmetic and the result is truncated to XLEN.
- valid_o stays 1 in RUN. A stall does not clear it; the downstream stage uses stall_i itself.
- Latency:
  - Redirect inputs sampled at edge N appear on pc_o after edge N.
  - pc_plus_o has zero latency relative to pc_o.
- Inputs that are X while rst_n = 0 have no effect.

Optional Feature:
- Macro: PC_ALIGN_CHK_EN.
- With the macro defined:
  - Adds output misalign_o (1 bit, registered, reset 0).
  - misalign_o is set for one cycle when a redirect target has any of bits [OFF_SHIFT-1:0] nonzero.
  - The PC is still loaded with the raw target; trap handling is the responsibility of the exception unit.
- Without it: no port is added, no check is made, and the target is loaded unchanged.

Test Plan:
- Reset and boot: RESET_PC = 32'h0000_3000; hold rst_n low 3 cycles, then release. Required: pc_o = 3000 and valid_o = 0 during reset; valid_o = 1 at the first edge with pc_o still 3000; then 3004, 3008.
- Stall: running at pc 0x40, assert stall_i for 2 cycles. Required: pc_o holds 0x40 for 2 cycles, then 0x44; flush_o stays 0.
- Branch with negative offset: br_base_i = 0x100, br_offset_i = -4 (0xFFFF_FFFC), br_taken_i = 1 for one cycle. Required: pc_o = 0xF0 next cycle, flush_o = 1 for one cycle, then 0xF4.
- Priority: jmp_i = 1 (target 0x800), br_taken_i = 1 and stall_i = 1 all in one cycle. Required: pc_o = 0x800 and flush_o = 1.
- Wrap-around: pc_o at 0xFFFF_FFFC with no events. Required: pc_o = 0x0000_0000, then 0x4.
- Async reset mid-redirect: pull rst_n low between edges while br_taken_i = 1. Required: pc_o = RESET_PC immediately with no clock, flush_o = 0, and the redirect is lost.
- With PC_ALIGN_CHK_EN defined: jmp_target_i = 0x802. Required: misalign_o = 1 for one cycle and pc_o = 0x802.
